// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file constants, data type and address-width helper
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    typedef logic [RF_XLEN-1:0] rf_data_t;

    // A one-entry file still needs a 1-bit address port.
    function automatic int rf_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - per-register write enable and winning data across all write ports
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NWR      = 1,
    parameter int HAS_ZERO = 1,
    parameter int AW       = rf_aw(NREGS)
) (
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    output logic [NREGS-1:0]      reg_we,
    output logic [NREGS*XLEN-1:0] reg_wdata
);

    // Ports scanned in ascending order so the highest-indexed effective write wins;
    // addresses >= NREGS never match any register and drop out naturally.
    always_comb begin
        reg_we    = '0;
        reg_wdata = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r)) && !(HAS_ZERO != 0 && r == 0)) begin
                    reg_we[r]                  = 1'b1;
                    reg_wdata[r*XLEN +: XLEN]  = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write-through bypass and busy scoreboard
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int HAS_ZERO = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_set_addr,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0]       regs [NREGS];
    logic [NREGS-1:0]      busy;
    logic [NREGS-1:0]      busy_nxt;
    logic [NREGS-1:0]      reg_we;
    logic [NREGS*XLEN-1:0] reg_wdata;
    logic [NRD*XLEN-1:0]   rd_val;
    logic [NRD-1:0]        rd_bsy;

    rf_write_arbiter #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NWR      (NWR),
        .HAS_ZERO (HAS_ZERO),
        .AW       (AW)
    ) u_arb (
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata)
    );

    // Completion clears, then a new issue re-sets: the newer producer wins.
    always_comb begin
        busy_nxt = busy & ~reg_we;
        for (int r = 0; r < NREGS; r++) begin
            if (sb_set && (sb_set_addr == AW'(r)) && !(HAS_ZERO != 0 && r == 0)) begin
                busy_nxt[r] = 1'b1;
            end
        end
    end

    // Unmatched (out-of-range) addresses and the zero register read as 0.
    always_comb begin
        rd_val = '0;
        rd_bsy = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int r = 0; r < NREGS; r++) begin
                if ((rd_addr[i*AW +: AW] == AW'(r)) && !(HAS_ZERO != 0 && r == 0)) begin
                    rd_val[i*XLEN +: XLEN] = reg_we[r] ? reg_wdata[r*XLEN +: XLEN] : regs[r];
                    rd_bsy[i]              = busy_nxt[r];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy    <= '0;
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (reg_we[r]) begin
                    regs[r] <= reg_wdata[r*XLEN +: XLEN];
                end
            end
            busy <= busy_nxt;
            for (int i = 0; i < NRD; i++) begin
                if (rd_en[i]) begin
                    rd_data[i*XLEN +: XLEN] <= rd_val[i*XLEN +: XLEN];
                    rd_busy[i]              <= rd_bsy[i];
                end
            end
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp (24 regs, 2R/2W, zero reg)
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 24;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                  clk;
    logic                  reset_n;
    logic [NRD-1:0]        rd_en;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR*AW-1:0]     wr_addr;
    logic [NWR*XLEN-1:0]   wr_data;
    logic                  sb_set;
    logic [AW-1:0]         sb_set_addr;
    logic [NREGS-1:0]      busy_vec;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_mp #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .HAS_ZERO (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_en       = '0;
        rd_addr     = '0;
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        sb_set      = 1'b0;
        sb_set_addr = '0;
    endtask

    task automatic rd(input int i, input logic [AW-1:0] a);
        rd_en[i]            = 1'b1;
        rd_addr[i*AW +: AW] = a;
    endtask

    task automatic wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[j]                = 1'b1;
        wr_addr[j*AW +: AW]     = a;
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic sb(input logic [AW-1:0] a);
        sb_set      = 1'b1;
        sb_set_addr = a;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        #3;
        check("reset_rd_data0", rd_data[31:0], 32'h0);
        check("reset_rd_data1", rd_data[63:32], 32'h0);
        check("reset_busy_vec", 32'(busy_vec), 32'h0);
        check("reset_rd_busy", 32'(rd_busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Asynchronous reset mid-operation
        wr(0, 5'd5, 32'hDEADBEEF); sb(5'd2);
        step();
        rd(0, 5'd5);
        step();
        check("pre_reset_r5", rd_data[31:0], 32'hDEADBEEF);
        check("pre_reset_busy", 32'(busy_vec), 32'h4);
        reset_n = 1'b0;
        #1;
        check("async_reset_rd_data", rd_data[31:0], 32'h0);
        check("async_reset_busy", 32'(busy_vec), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        rd(0, 5'd5);
        step();
        check("post_reset_r5", rd_data[31:0], 32'h0);

        // Write-through bypass
        wr(0, 5'd7, 32'h12345678); rd(1, 5'd7);
        step();
        check("bypass_rd1", rd_data[63:32], 32'h12345678);
        rd(0, 5'd7);
        step();
        check("stored_r7", rd_data[31:0], 32'h12345678);

        // Zero register and out-of-range address
        wr(0, 5'd0, 32'hFFFFFFFF); rd(0, 5'd0);
        step();
        check("r0_bypass", rd_data[31:0], 32'h0);
        rd(1, 5'd0);
        step();
        check("r0_stored", rd_data[63:32], 32'h0);
        rd(0, 5'd7);
        step();
        wr(1, 5'd30, 32'hABCD1234); rd(0, 5'd30);
        step();
        check("r30_bypass", rd_data[31:0], 32'h0);
        rd(1, 5'd30);
        step();
        check("r30_stored", rd_data[63:32], 32'h0);
        sb(5'd0);
        step();
        check("sb_r0_ignored", 32'(busy_vec), 32'h0);
        sb(5'd30);
        step();
        check("sb_r30_ignored", 32'(busy_vec), 32'h0);

        // Write conflict: port 1 wins
        wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); rd(0, 5'd3);
        step();
        check("conflict_bypass", rd_data[31:0], 32'h22);
        rd(1, 5'd3);
        step();
        check("conflict_stored", rd_data[63:32], 32'h22);

        // Scoreboard
        sb(5'd9);
        step();
        check("sb_set_r9", 32'(busy_vec), 32'h200);
        rd(0, 5'd9);
        step();
        check("rd_busy_r9", 32'(rd_busy[0]), 32'h1);
        wr(0, 5'd9, 32'h5); sb(5'd9); rd(1, 5'd9);
        step();
        check("set_beats_clear", 32'(busy_vec), 32'h200);
        check("set_clear_rd_busy", 32'(rd_busy[1]), 32'h1);
        check("set_clear_data", rd_data[63:32], 32'h5);
        wr(1, 5'd9, 32'h6); rd(0, 5'd9);
        step();
        check("clear_r9", 32'(busy_vec), 32'h0);
        check("clear_rd_busy", 32'(rd_busy[0]), 32'h0);
        check("clear_data", rd_data[31:0], 32'h6);

        // Read hold while disabled
        wr(0, 5'd4, 32'hA5);
        step();
        rd(0, 5'd4);
        step();
        check("hold_initial", rd_data[31:0], 32'hA5);
        wr(0, 5'd4, 32'h5A);
        step();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("hold_cycle%0d", k), rd_data[31:0], 32'hA5);
            step();
        end
        check("hold_cycle2", rd_data[31:0], 32'hA5);
        rd(0, 5'd4);
        step();
        check("hold_reenable", rd_data[31:0], 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
